// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {StPor, StInit, StIdle, StAddr, StChar} lcd_state_e;

  typedef enum logic [1:0] {XactIdle, XactSetup, XactPulse, XactWait} xact_phase_e;

  localparam logic [7:0] CmdFuncSet = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CmdDispOn  = 8'h0C;
  localparam logic [7:0] CmdClear   = 8'h01;
  localparam logic [7:0] CmdEntry   = 8'h06;

  localparam logic [7:0] RowBase0 = 8'h80;
  localparam logic [7:0] RowBase1 = 8'hC0;
  localparam logic [7:0] RowBase2 = 8'h94;
  localparam logic [7:0] RowBase3 = 8'hD4;

  localparam logic [7:0] CharSpace = 8'h20;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0: cmd = CmdFuncSet;
      2'd1: cmd = CmdDispOn;
      2'd2: cmd = CmdClear;
      2'd3: cmd = CmdEntry;
    endcase
    return cmd;
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] row);
    logic [7:0] addr;
    unique case (row)
      2'd0: addr = RowBase0;
      2'd1: addr = RowBase1;
      2'd2: addr = RowBase2;
      2'd3: addr = RowBase3;
    endcase
    return addr;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_xact.sv
// One HD44780 bus transaction: SETUP (1 clk), PULSE (EN high), then a settle WAIT.
module lcd_bus_xact
  import lcd_pkg::*;
#(
  parameter int unsigned EN_CYCLES = 20,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned CLR_WAIT  = 80000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  localparam logic [CNT_W-1:0] EnLast  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CmdLast = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] ClrLast = CNT_W'(CLR_WAIT - 1);

  xact_phase_e      phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_q, long_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic [7:0]       data_q, data_d;
  logic             done;

  assign done    = (phase_q == XactWait) && (cnt_q == (long_q ? ClrLast : CmdLast));
  // Accepting a start on the last WAIT cycle keeps transactions back-to-back.
  assign ready_o = (phase_q == XactIdle) || done;
  assign done_o  = done;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    rs_d    = rs_q;
    data_d  = data_q;
    en_d    = 1'b0;
    unique case (phase_q)
      XactIdle: ;
      XactSetup: begin
        phase_d = XactPulse;
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      XactPulse: begin
        if (cnt_q == EnLast) begin
          phase_d = XactWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          en_d  = 1'b1;
        end
      end
      XactWait: begin
        if (done) phase_d = XactIdle;
        else      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: phase_d = XactIdle;
    endcase
    if (start_i && ready_o) begin
      phase_d = XactSetup;
      cnt_d   = '0;
      rs_d    = rs_i;
      data_d  = data_i;
      long_d  = long_wait_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= XactIdle;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 controller: power-on wait, init sequence, then continuous refresh
// of a ROWS x COLS character buffer onto the 8-bit LCD bus.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned EN_CYCLES = 20,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned CLR_WAIT  = 80000,
  parameter int unsigned POR_WAIT  = 800000
) (
  input  logic       LCD_Clk,
  input  logic       LCD_Rst,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       refresh_en,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int unsigned MaxWait = max_u(max_u(POR_WAIT, CLR_WAIT), max_u(CMD_WAIT, EN_CYCLES));
  localparam int unsigned CntW    = $clog2(MaxWait + 1);
  localparam int          Cells   = ROWS * COLS;
  localparam int unsigned IdxW    = $clog2(Cells);

  localparam logic [CntW-1:0] PorLast = CntW'(POR_WAIT - 1);
  localparam logic [5:0]      ColLast = 6'(COLS - 1);
  localparam logic [1:0]      RowLast = 2'(ROWS - 1);

  lcd_state_e      state_q, state_d;
  logic [CntW-1:0] por_cnt_q, por_cnt_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic [1:0]      row_q, row_d;
  logic [5:0]      col_q, col_d;
  logic            init_done_q, init_done_d;
  logic            frame_pend_q, frame_pend_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      buf_q [Cells];

  logic            x_start, x_rs, x_long, x_ready, x_done;
  logic [7:0]      x_data;
  logic            wr_ok;
  logic [IdxW-1:0] wr_idx, rd_idx;

  // Range check before flattening so out-of-range writes cannot alias onto another row.
  assign wr_ok  = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign wr_idx = IdxW'(32'(wr_row) * COLS + 32'(wr_col));
  assign rd_idx = IdxW'(32'(row_q) * COLS + 32'(col_q));

  always_ff @(posedge LCD_Clk) begin
    if (LCD_Rst) begin
      for (int i = 0; i < Cells; i++) buf_q[i] <= CharSpace;
    end else if (wr_ok) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    por_cnt_d    = por_cnt_q;
    init_idx_d   = init_idx_q;
    row_d        = row_q;
    col_d        = col_q;
    init_done_d  = init_done_q;
    frame_pend_d = frame_pend_q;
    frame_done_d = 1'b0;
    x_start      = 1'b0;
    x_rs         = 1'b0;
    x_data       = 8'h00;
    x_long       = 1'b0;
    if (frame_pend_q && x_done) begin
      frame_done_d = 1'b1;
      frame_pend_d = 1'b0;
    end
    // Each issuing state fires on x_ready and moves on immediately; the
    // transaction timer holds off the next issue until its WAIT expires.
    unique case (state_q)
      StPor: begin
        if (por_cnt_q == PorLast) begin
          state_d   = StInit;
          por_cnt_d = '0;
        end else begin
          por_cnt_d = por_cnt_q + CntW'(1);
        end
      end
      StInit: begin
        if (x_ready) begin
          x_start = 1'b1;
          x_data  = init_cmd(init_idx_q);
          x_long  = (init_idx_q == 2'd2);
          if (init_idx_q == 2'd3) state_d    = StIdle;
          else                    init_idx_d = init_idx_q + 2'd1;
        end
      end
      StIdle: begin
        if (x_ready) begin
          init_done_d = 1'b1;
          if (refresh_en) begin
            state_d = StAddr;
            row_d   = 2'd0;
          end
        end
      end
      StAddr: begin
        if (x_ready) begin
          x_start = 1'b1;
          x_data  = row_base(row_q);
          col_d   = 6'd0;
          state_d = StChar;
        end
      end
      StChar: begin
        if (x_ready) begin
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = buf_q[rd_idx];
          if (col_q == ColLast) begin
            if (row_q == RowLast) begin
              state_d      = StIdle;
              frame_pend_d = 1'b1;
            end else begin
              row_d   = row_q + 2'd1;
              state_d = StAddr;
            end
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      default: state_d = StPor;
    endcase
  end

  always_ff @(posedge LCD_Clk) begin
    if (LCD_Rst) begin
      state_q      <= StPor;
      por_cnt_q    <= '0;
      init_idx_q   <= 2'd0;
      row_q        <= 2'd0;
      col_q        <= 6'd0;
      init_done_q  <= 1'b0;
      frame_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      init_idx_q   <= init_idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      init_done_q  <= init_done_d;
      frame_pend_q <= frame_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_bus_xact #(
    .EN_CYCLES(EN_CYCLES),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT),
    .CNT_W    (CntW)
  ) u_xact (
    .clk_i      (LCD_Clk),
    .rst_i      (LCD_Rst),
    .start_i    (x_start),
    .rs_i       (x_rs),
    .data_i     (x_data),
    .long_wait_i(x_long),
    .ready_o    (x_ready),
    .done_o     (x_done),
    .lcd_rs_o   (LCD_RS),
    .lcd_en_o   (LCD_EN),
    .lcd_data_o (lcd_data)
  );

  assign LCD_RW     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: expected bus bytes are queued with the stimulus and
// popped by a monitor on every rising edge of LCD_EN.
module tb_lcd_hd44780_ctrl;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROWS      = 2;
  localparam int unsigned EN_CYCLES = 2;
  localparam int unsigned CMD_WAIT  = 3;
  localparam int unsigned CLR_WAIT  = 10;
  localparam int unsigned POR_WAIT  = 20;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [7:0] gap;  // EN-low clocks expected before this pulse, 0 = unchecked
  } exp_t;

  logic       clk = 1'b0;
  logic       LCD_Rst, wr_en, refresh_en;
  logic [1:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_data;
  logic       LCD_RS, LCD_RW, LCD_EN, init_done, frame_done;
  logic [7:0] lcd_data;

  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  model [ROWS][COLS];
  logic [7:0]  bases [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, hi_cnt = 0, lo_cnt = 0, addr0_cyc = 0, fd_cnt = 0;
  logic        en_prev = 1'b0;
  logic        mon_skip = 1'b1;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .EN_CYCLES(EN_CYCLES),
    .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT), .POR_WAIT(POR_WAIT)
  ) dut (
    .LCD_Clk   (clk),
    .LCD_Rst   (LCD_Rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .refresh_en(refresh_en),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_EN    (LCD_EN),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Monitor samples 1 time unit after the falling edge; main stimulus at +2.
  always @(negedge clk) begin
    #1;
    cyc++;
    fd_cnt += 32'(frame_done === 1'b1);
    if (LCD_EN === 1'b1) begin
      if (en_prev !== 1'b1) begin
        check_eq("en_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("bus_rs_data", {23'd0, LCD_RS, lcd_data}, {23'd0, e.rs, e.data});
          if (e.gap != 8'd0) check_eq("en_gap", lo_cnt, 32'(e.gap));
          if (!e.rs && e.data == 8'h80) addr0_cyc = cyc;
        end
        hi_cnt = 0;
      end
      hi_cnt++;
    end else begin
      if (en_prev === 1'b1) begin
        if (!mon_skip) check_eq("en_width", hi_cnt, EN_CYCLES);
        lo_cnt = 0;
      end
      lo_cnt++;
    end
    en_prev = LCD_EN;
  end

  task automatic push_exp(input logic rs, input logic [7:0] data, input logic [7:0] gap);
    exp_t x;
    x.rs   = rs;
    x.data = data;
    x.gap  = gap;
    exp_q.push_back(x);
  endtask

  // Gap = WAIT clocks of the previous transaction + 1 SETUP clock.
  task automatic push_init();
    push_exp(1'b0, 8'h38, 8'd0);
    push_exp(1'b0, 8'h0C, 8'(CMD_WAIT + 1));
    push_exp(1'b0, 8'h01, 8'(CMD_WAIT + 1));
    push_exp(1'b0, 8'h06, 8'(CLR_WAIT + 1));
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++) begin
      push_exp(1'b0, bases[r], (r == 0) ? 8'd0 : 8'(CMD_WAIT + 1));
      for (int c = 0; c < COLS; c++) push_exp(1'b1, model[r][c], 8'(CMD_WAIT + 1));
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
  endtask

  task automatic write_cell(input int unsigned r, input int unsigned c, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_row  = 2'(r);
    wr_col  = 6'(c);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) model[r][c] = d;
  endtask

  task automatic por_and_init(input string tag);
    int unsigned en_hi = 0;
    for (int i = 0; i < int'(POR_WAIT); i++) begin
      tick();
      en_hi += 32'(LCD_EN === 1'b1);
    end
    check_eq({tag, "_por_quiet"}, en_hi, 0);
    for (int i = 0; i < 200; i++) begin
      if (init_done === 1'b1) break;
      tick();
    end
    check_eq({tag, "_init_done"}, 32'(init_done), 1);
    check_eq({tag, "_init_left"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input string tag);
    int unsigned n0, fd0;
    int unsigned en_hi = 0;
    push_frame();
    n0  = exp_q.size();
    fd0 = fd_cnt;
    refresh_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() < n0) break;
      tick();
    end
    check_eq({tag, "_start"}, 32'(exp_q.size() < n0), 1);
    refresh_en = 1'b0;  // mid-frame drop must not abort the frame
    for (int i = 0; i < 200; i++) begin
      if (frame_done === 1'b1) break;
      tick();
    end
    check_eq({tag, "_done"}, 32'(frame_done), 1);
    // Frame starts at the 0x80 SETUP clock, one before its EN rise.
    check_eq({tag, "_done_time"}, cyc - addr0_cyc + 1, 60);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    tick();
    check_eq({tag, "_done_pulse"}, 32'(frame_done), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      en_hi += 32'(LCD_EN === 1'b1);
    end
    check_eq({tag, "_idle_quiet"}, en_hi, 0);
    check_eq({tag, "_done_count"}, fd_cnt - fd0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    LCD_Rst = 1'b1; wr_en = 1'b0; refresh_en = 1'b0;
    wr_row = 2'd0; wr_col = 6'd0; wr_data = 8'h00;
    model_reset();
    repeat (3) tick();
    check_eq("rst_en", 32'(LCD_EN), 0);
    check_eq("rst_rs", 32'(LCD_RS), 0);
    check_eq("rst_rw", 32'(LCD_RW), 0);
    check_eq("rst_data", 32'(lcd_data), 0);
    check_eq("rst_init_done", 32'(init_done), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    push_init();
    LCD_Rst  = 1'b0;
    mon_skip = 1'b0;
    por_and_init("boot");

    run_frame("blank");

    write_cell(1, 3, 8'h41);
    write_cell(0, 0, 8'h42);
    run_frame("chars");

    write_cell(1, 3, 8'h20);
    write_cell(0, 0, 8'h20);
    write_cell(2, 0, 8'h55);
    write_cell(0, 4, 8'h66);
    write_cell(3, 3, 8'h77);
    run_frame("oob");

    // Reset during the 0x80 EN pulse of a frame with a non-blank cell.
    write_cell(1, 3, 8'h41);
    push_frame();
    refresh_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (LCD_EN === 1'b1) break;
      tick();
    end
    check_eq("mid_pulse_en", 32'(LCD_EN), 1);
    mon_skip   = 1'b1;
    LCD_Rst    = 1'b1;
    refresh_en = 1'b0;
    tick();
    check_eq("mid_rst_en", 32'(LCD_EN), 0);
    check_eq("mid_rst_init_done", 32'(init_done), 0);
    check_eq("mid_rst_data", 32'(lcd_data), 0);
    exp_q.delete();
    model_reset();
    push_init();
    LCD_Rst = 1'b0;
    tick();
    mon_skip = 1'b0;
    por_and_init("reboot");
    run_frame("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
